// File: rtl/regfile_sb.sv
// ----------------------------------------------------------------------------
// regfile_sb
//
// General-purpose register file with two combinational read ports, one write
// port and a per-register busy scoreboard. Decode reads operands and busy
// flags and reserves destinations; writeback writes results and releases the
// reservation. Register 0 is hardwired to zero and can never be busy.
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   rs, rt          read indices for port A / port B
//   result1/2       read data for rs / rt
//   busy1/2         busy flag of rs / rt
//   iss_valid       decode requests a reservation of iss_rd
//   iss_rd          destination index to reserve
//   iss_ready       reservation accepted this cycle
//   RegWr, rw, Di   writeback enable, index and data
//   busy_cnt        number of registers currently busy (registered count)
//
// Handshake: a reservation takes effect at the rising edge where
// iss_valid && iss_ready. iss_ready never asserts without iss_valid. A
// rejected request has no effect; decode holds iss_valid/iss_rd and retries.
//
// Build option: define RFILE_BYPASS_EN for write-first forwarding from the
// writeback port to both read ports. Without it, a write becomes visible on
// the read ports the cycle after its edge.
// ----------------------------------------------------------------------------
module regfile_sb #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rs,
  input  logic [ADDR_W-1:0] rt,
  output logic [DATA_W-1:0] result1,
  output logic [DATA_W-1:0] result2,
  output logic              busy1,
  output logic              busy2,
  input  logic              iss_valid,
  input  logic [ADDR_W-1:0] iss_rd,
  output logic              iss_ready,
  input  logic              RegWr,
  input  logic [ADDR_W-1:0] rw,
  input  logic [DATA_W-1:0] Di,
  output logic [ADDR_W:0]   busy_cnt
);

  localparam int DEPTH = 1 << ADDR_W;
  localparam logic [ADDR_W:0] CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem [DEPTH];
  logic [DEPTH-1:0]  busy;
  logic [DEPTH-1:0]  busy_next;

  logic wr_en;
  logic set_en;
  logic clr_en;

  // Writes to index 0 are dropped so it always holds zero.
  assign wr_en = RegWr && (rw != '0);

  // A busy destination may still be reserved when writeback releases it in
  // the same cycle: the release and the new reservation hand over cleanly.
  assign iss_ready = iss_valid &&
                     ((iss_rd == '0) || !busy[iss_rd] || (RegWr && (rw == iss_rd)));

  // Reserving index 0 is accepted but never marks anything busy.
  assign set_en = iss_ready && (iss_rd != '0);
  // Only a write that actually clears a set bit counts as a release.
  assign clr_en = wr_en && busy[rw];

  // Read ports
  always_comb begin
    result1 = (rs == '0) ? '0 : mem[rs];
    result2 = (rt == '0) ? '0 : mem[rt];
    busy1   = (rs != '0) && busy[rs];
    busy2   = (rt != '0) && busy[rt];
`ifdef RFILE_BYPASS_EN
    // Forward the write in flight; a same-cycle reservation of the same index
    // only shows up as busy on the next cycle.
    if (wr_en && (rw == rs)) begin
      result1 = Di;
      busy1   = 1'b0;
    end
    if (wr_en && (rw == rt)) begin
      result2 = Di;
      busy2   = 1'b0;
    end
`endif
  end

  // Next busy vector: the clear is applied first so a same-index set wins.
  always_comb begin
    busy_next = busy;
    if (wr_en) busy_next[rw] = 1'b0;
    if (set_en) busy_next[iss_rd] = 1'b1;
  end

  // Register storage
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[rw] <= Di;
    end
  end

  // Scoreboard bits and running count. Set and clear in the same cycle
  // cancel whether or not they hit the same index: a same-index pair can only
  // happen on an already busy register, which stays busy.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy <= busy_next;
      case ({set_en, clr_en})
        2'b10:   busy_cnt <= busy_cnt + CNT_ONE;
        2'b01:   busy_cnt <= busy_cnt - CNT_ONE;
        default: busy_cnt <= busy_cnt;
      endcase
    end
  end

endmodule

// File: tb/tb_regfile_sb.sv
// ----------------------------------------------------------------------------
// tb_regfile_sb
//
// Bench for regfile_sb. A behavioural model (arrays of register values and
// busy flags, count taken as a popcount) is compared against every DUT
// output on each falling edge. Directed sequences with hand-computed values
// pin the model; a randomized phase follows.
// ----------------------------------------------------------------------------
module tb_regfile_sb;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;
  localparam int DEPTH  = 1 << ADDR_W;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic [ADDR_W-1:0] rs, rt, iss_rd, rw;
  logic [DATA_W-1:0] Di;
  logic              iss_valid, RegWr;
  logic [DATA_W-1:0] result1, result2;
  logic              busy1, busy2, iss_ready;
  logic [ADDR_W:0]   busy_cnt;

  regfile_sb #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
    .clk(clk), .rst(rst),
    .rs(rs), .rt(rt),
    .result1(result1), .result2(result2),
    .busy1(busy1), .busy2(busy2),
    .iss_valid(iss_valid), .iss_rd(iss_rd), .iss_ready(iss_ready),
    .RegWr(RegWr), .rw(rw), .Di(Di),
    .busy_cnt(busy_cnt)
  );

  // ---------------- scoreboard ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [DATA_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [DATA_W-1:0] m_reg  [DEPTH];
  bit                m_busy [DEPTH];

  function automatic logic [DATA_W-1:0] m_read(input logic [ADDR_W-1:0] idx);
    if (idx == 0) return '0;
`ifdef RFILE_BYPASS_EN
    if (RegWr && rw != 0 && rw == idx) return Di;
`endif
    return m_reg[idx];
  endfunction

  function automatic logic m_busy_rd(input logic [ADDR_W-1:0] idx);
    if (idx == 0) return 1'b0;
`ifdef RFILE_BYPASS_EN
    if (RegWr && rw != 0 && rw == idx) return 1'b0;
`endif
    return m_busy[idx];
  endfunction

  function automatic logic m_ready();
    return iss_valid && (iss_rd == 0 || !m_busy[iss_rd] || (RegWr && rw == iss_rd));
  endfunction

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < DEPTH; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        m_reg[i]  = '0;
        m_busy[i] = 1'b0;
      end
    end else begin
      logic acc;
      acc = m_ready();
      if (RegWr && rw != 0) begin
        m_reg[rw]  = Di;
        m_busy[rw] = 1'b0;
      end
      if (acc && iss_rd != 0) m_busy[iss_rd] = 1'b1;
    end
  end

  // Compare process: every output, every cycle.
  always @(negedge clk) begin
    check("result1", 64'(result1), 64'(m_read(rs)));
    check("result2", 64'(result2), 64'(m_read(rt)));
    check("busy1", 64'(busy1), 64'(m_busy_rd(rs)));
    check("busy2", 64'(busy2), 64'(m_busy_rd(rt)));
    check("iss_ready", 64'(iss_ready), 64'(m_ready()));
    check("busy_cnt", 64'(busy_cnt), 64'(m_count()));
  end

  // ---------------- driver ----------------
  task automatic apply(input logic [ADDR_W-1:0] a, input logic [ADDR_W-1:0] b,
                       input logic v, input logic [ADDR_W-1:0] d,
                       input logic w, input logic [ADDR_W-1:0] wi,
                       input logic [DATA_W-1:0] data);
    @(posedge clk);
    #1;
    rs = a; rt = b; iss_valid = v; iss_rd = d; RegWr = w; rw = wi; Di = data;
    @(negedge clk);
  endtask

  function automatic logic [ADDR_W-1:0] rnd_idx();
    if ($urandom_range(0, 1) == 1) return ADDR_W'($urandom_range(0, 7));
    return ADDR_W'($urandom_range(0, DEPTH - 1));
  endfunction

  // ---------------- directed + random stimulus ----------------
  initial begin
    rst = 1'b1;
    rs = '0; rt = '0; iss_valid = 1'b1; iss_rd = 5'd4; RegWr = 1'b1; rw = 5'd4; Di = 32'h1234;

    // Reset state; iss_ready follows iss_valid while in reset
    @(negedge clk);
    check("rst_result1", 64'(result1), 64'h0);
    check("rst_cnt", 64'(busy_cnt), 64'h0);
    check("rst_ready", 64'(iss_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    RegWr = 1'b0; iss_valid = 1'b0;

    // Write / read
    apply(0, 0, 0, 0, 1, 5, 32'hDEADBEEF);  exp_q.push_back(32'hDEADBEEF);
    apply(0, 0, 0, 0, 1, 31, 32'h12345678); exp_q.push_back(32'h12345678);
    apply(5, 31, 0, 0, 0, 0, 0);
    check("rd_r5", 64'(result1), 64'(exp_q.pop_front()));
    check("rd_r31", 64'(result2), 64'(exp_q.pop_front()));
    apply(0, 0, 0, 0, 1, 0, 32'hFFFFFFFF);
    apply(0, 5, 0, 0, 0, 0, 0);
    check("rd_r0", 64'(result1), 64'h0);

    // Scoreboard reserve / reject / release
    apply(0, 0, 1, 3, 0, 0, 0);
    check("res_r3_ready", 64'(iss_ready), 64'h1);
    apply(3, 0, 1, 3, 0, 0, 0);
    check("r3_busy", 64'(busy1), 64'h1);
    check("r3_cnt", 64'(busy_cnt), 64'h1);
    check("r3_reject", 64'(iss_ready), 64'h0);
    apply(3, 0, 0, 0, 1, 3, 32'h55);
    check("r3_cnt_wr", 64'(busy_cnt), 64'h1);
    apply(3, 0, 0, 0, 0, 0, 0);
    check("r3_clear", 64'(busy1), 64'h0);
    check("r3_cnt0", 64'(busy_cnt), 64'h0);
    check("r3_data", 64'(result1), 64'h55);

    // Release+reserve same index; reserve and release different indices
    apply(0, 0, 1, 9, 0, 0, 0);
    apply(0, 0, 1, 6, 0, 0, 0);
    apply(9, 0, 1, 9, 1, 9, 32'h99);
    check("r9_handover_ready", 64'(iss_ready), 64'h1);
    check("r9_cnt_pre", 64'(busy_cnt), 64'h2);
    apply(9, 6, 1, 4, 1, 6, 32'h66);
    check("r9_data", 64'(result1), 64'h99);
    check("r9_busy", 64'(busy1), 64'h1);
    check("r9_cnt", 64'(busy_cnt), 64'h2);
    apply(6, 4, 0, 0, 0, 0, 0);
    check("r6_data", 64'(result1), 64'h66);
    check("r6_free", 64'(busy1), 64'h0);
    check("r4_busy", 64'(busy2), 64'h1);
    check("r4_r6_cnt", 64'(busy_cnt), 64'h2);

    // Bypass behaviour
    apply(0, 0, 0, 0, 1, 12, 32'h11);
    apply(12, 0, 0, 0, 1, 12, 32'hA5A5A5A5);
`ifdef RFILE_BYPASS_EN
    check("byp_same", 64'(result1), 64'hA5A5A5A5);
`else
    check("byp_same", 64'(result1), 64'h11);
`endif
    apply(12, 0, 0, 0, 0, 0, 0);
    check("byp_next", 64'(result1), 64'hA5A5A5A5);

    // Mid-cycle asynchronous reset
    apply(5, 9, 1, 9, 0, 0, 0);
    check("pre_rst_r5", 64'(result1), 64'hDEADBEEF);
    #2 rst = 1'b1;
    #1;
    check("arst_result1", 64'(result1), 64'h0);
    check("arst_busy2", 64'(busy2), 64'h0);
    check("arst_cnt", 64'(busy_cnt), 64'h0);
    check("arst_ready", 64'(iss_ready), 64'h1);
    @(negedge clk);
    rst = 1'b0;
    apply(7, 5, 0, 0, 0, 0, 0);
    check("post_rst_r7", 64'(result1), 64'h0);
    check("post_rst_r5", 64'(result2), 64'h0);

    // Fill the scoreboard
    for (int i = 1; i < DEPTH; i++) apply(0, 0, 1, ADDR_W'(i), 0, 0, 0);
    apply(31, 1, 1, 0, 0, 0, 0);
    check("fill_cnt", 64'(busy_cnt), 64'd31);
    check("fill_r0_ready", 64'(iss_ready), 64'h1);
    apply(31, 0, 1, 5, 0, 0, 0);
    check("fill_cnt_hold", 64'(busy_cnt), 64'd31);
    check("fill_r5_reject", 64'(iss_ready), 64'h0);

    // Randomized traffic
    for (int n = 0; n < 3000; n++) begin
      apply(rnd_idx(), rnd_idx(), 1'($urandom_range(0, 1)), rnd_idx(),
            1'($urandom_range(0, 1)), rnd_idx(), $urandom);
    end

    apply(0, 0, 0, 0, 0, 0, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised general-purpose register file with two asynchronous read ports, one write port and an integrated per-register busy scoreboard. It sits between decode and writeback in the pipelined CPU. Decode reads operands and busy flags and reserves destinations; writeback writes results and releases reservations. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_W, 32, register width in bits
- ADDR_W, 5, register index width; depth = 2**ADDR_W

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- rs  in  ADDR_W  read port A index
- rt  in  ADDR_W  read port B index
- result1  out  DATA_W  read port A data
- result2  out  DATA_W  read port B data
- busy1  out  1  register rs has a pending producer
- busy2  out  1  register rt has a pending producer
- iss_valid  in  1  decode requests reservation of iss_rd
- iss_rd  in  ADDR_W  destination index to reserve
- iss_ready  out  1  reservation accepted this cycle
- RegWr  in  1  writeback write enable
- rw  in  ADDR_W  writeback index
- Di  in  DATA_W  writeback data
- busy_cnt  out  ADDR_W+1  number of registers currently busy

## Operation
- Storage: 2**ADDR_W words of DATA_W bits, plus one busy bit per register.
- Reads are combinational: result1 = reg[rs], result2 = reg[rt]. busy1 = busy[rs] and busy2 = busy[rt].
- Index 0 always reads 0 with busy 0. Writes to 0 are ignored. Reservations of 0 are accepted (iss_ready=1) but set no bit.
- Write: if RegWr and rw≠0, reg[rw] ← Di and busy[rw] ← 0 at the rising edge.
- Reserve: iss_ready = iss_valid and (iss_rd==0 or !busy[iss_rd] or (RegWr and rw==iss_rd)). When iss_ready, busy[iss_rd] ← 1 at the edge.
- Same index released and reserved in one cycle: the set wins, so the bit ends at 1. The data write still occurs.
- iss_valid=0 gives iss_ready=0. A rejected request has no state effect; decode must hold and retry.
- busy_cnt tracks the popcount of busy bits. It updates at the same edge as the bits and is a registered counter, not recomputed: +1 on set, −1 on clear, unchanged on set+clear of the same index. Set and clear of different indices in one cycle leave the count unchanged.
- busy_cnt never exceeds 2**ADDR_W−1. A write to a non-busy register does not decrement it.

## Timing
- Reset (async assert, sync-safe deassert by the system): all registers 0, all busy bits 0, busy_cnt 0. Outputs during reset: result1/result2 0, busy1/busy2 0, iss_ready = iss_valid.
- Reset mid-operation discards all reservations and data immediately. No write or reserve at a clock edge coinciding with rst high takes effect.
- Write latency: data is visible on read ports the cycle after the write edge (bypass disabled).
- Reserve latency: busy1/busy2 assert the cycle after the accepting edge.
- iss_ready is combinational from iss_valid, iss_rd, RegWr, rw and state. No combinational path exists from iss_valid to result*/busy*.

## Configuration
- RFILE_BYPASS_EN defined: write-first forwarding.
  - If RegWr and rw≠0 and rs==rw, then result1 = Di and busy1 = 0 in the same cycle. The same applies to rt/result2/busy2.
  - A same-cycle reserve of that index does not suppress the bypass. Data is forwarded, and busy asserts next cycle.
- RFILE_BYPASS_EN undefined:
  - Reads return the pre-write value and pre-clear busy during the write cycle.
  - New value and cleared busy are visible next cycle.
- The macro affects nothing else.

## Test plan
- Reset: preload via writes, assert rst mid-cycle → all reads 0, busy_cnt 0 asynchronously; after release, reg 7 reads 0.
- Write/read: write 0xDEADBEEF to r5, 0x12345678 to r31 → next cycle rs=5, rt=31 give both values; write 0xFFFFFFFF to r0 → r0 reads 0.
- Scoreboard: reserve r3 → busy1(rs=3)=1, busy_cnt=1; reserve r3 again → iss_ready=0; write r3=0x55 → busy clears, busy_cnt=0.
- Simultaneous release+reserve of r9 (busy) → iss_ready=1, r9 data updated, busy[9] stays 1, busy_cnt unchanged; reserve r4 while writing busy r6 → busy_cnt unchanged.
- Bypass: write 0xA5A5A5A5 to r12 with rs=12 → with RFILE_BYPASS_EN, result1=0xA5A5A5A5 same cycle; without it, the old value that cycle and new next cycle.
- Fill: reserve r1..r31 consecutively → busy_cnt=31, reserving r0 still ready, count stays 31.
